// File: rtl/nf_ahb_gpio_irq.sv
// rtl/nf_ahb_gpio_irq.sv - AHB-Lite GPIO slave with atomic output ops and edge interrupts
//
// Purpose: zero-wait-state AHB-Lite slave exposing gpio_w pins with
//   set/clear/toggle of outputs, a sync_stages-deep input synchroniser,
//   per-pin edge-detect interrupt status (write-1-to-clear) and one
//   level interrupt line to the core.
// Ports:
//   hclk, hresetn      clock, asynchronous active-low reset
//   haddr_s[5:2]       word offset of the register (other bits ignored)
//   hwdata_s/hrdata_s  data-phase write/read data
//   hwrite_s, htrans_s, hsel_s   request qualifiers
//   hsize_s, hburst_s  ignored, every access is a 32-bit word
//   hresp_s, hready_s  constant OKAY / ready
//   gpi, gpo, gpd      pin input, output value, direction (1 = output)
//   irq                |(ISTAT & IEN)
module nf_ahb_gpio_irq #(
  parameter int gpio_w      = 8,
  parameter int sync_stages = 2
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic [31:0]       haddr_s,
  input  logic [31:0]       hwdata_s,
  output logic [31:0]       hrdata_s,
  input  logic              hwrite_s,
  input  logic [1:0]        htrans_s,
  input  logic [2:0]        hsize_s,
  input  logic [2:0]        hburst_s,
  output logic [1:0]        hresp_s,
  output logic              hready_s,
  input  logic              hsel_s,
  input  logic [gpio_w-1:0] gpi,
  output logic [gpio_w-1:0] gpo,
  output logic [gpio_w-1:0] gpd,
  output logic              irq
);

  localparam logic [3:0] A_GPI   = 4'h0;
  localparam logic [3:0] A_GPO   = 4'h1;
  localparam logic [3:0] A_GPD   = 4'h2;
  localparam logic [3:0] A_SET   = 4'h3;
  localparam logic [3:0] A_CLR   = 4'h4;
  localparam logic [3:0] A_TGL   = 4'h5;
  localparam logic [3:0] A_IEN   = 4'h6;
  localparam logic [3:0] A_IRISE = 4'h7;
  localparam logic [3:0] A_IBOTH = 4'h8;
  localparam logic [3:0] A_ISTAT = 4'h9;

  logic              r_valid;
  logic              r_write;
  logic [3:0]        r_addr;
  logic [gpio_w-1:0] r_sync [sync_stages];
  logic [gpio_w-1:0] r_gpi_p;
  logic [gpio_w-1:0] r_gpo;
  logic [gpio_w-1:0] r_gpd;
  logic [gpio_w-1:0] r_ien;
  logic [gpio_w-1:0] r_irise;
  logic [gpio_w-1:0] r_iboth;
  logic [gpio_w-1:0] r_istat;

  logic              w_req;
  logic              w_wr;
  logic [gpio_w-1:0] w_gpi_s;
  logic [gpio_w-1:0] w_rise;
  logic [gpio_w-1:0] w_fall;
  logic [gpio_w-1:0] w_edge;
  logic [gpio_w-1:0] w_wd;
  logic [gpio_w-1:0] w_w1c;
  logic [gpio_w-1:0] w_rd;
  logic              w_unused;

  // Size, burst and the undecoded address/data bits carry no meaning here.
  assign w_unused = ^{hsize_s, hburst_s, haddr_s[31:6], haddr_s[1:0], hwdata_s};

  assign hresp_s  = 2'b00;
  assign hready_s = 1'b1;

  // Address phase capture; the slave is always ready so no hready gating.
  assign w_req = hsel_s && (htrans_s != 2'b00);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= 4'h0;
    end else begin
      r_valid <= w_req;
      if (w_req) begin
        r_write <= hwrite_s;
        r_addr  <= haddr_s[5:2];
      end
    end
  end

  // Input synchroniser followed by one extra stage for edge detection.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int k = 0; k < sync_stages; k++) r_sync[k] <= '0;
      r_gpi_p <= '0;
    end else begin
      r_sync[0] <= gpi;
      for (int k = 1; k < sync_stages; k++) r_sync[k] <= r_sync[k-1];
      r_gpi_p <= w_gpi_s;
    end
  end

  assign w_gpi_s = r_sync[sync_stages-1];
  assign w_rise  = w_gpi_s & ~r_gpi_p;
  assign w_fall  = ~w_gpi_s & r_gpi_p;
  assign w_edge  = (r_iboth & (w_rise | w_fall)) |
                   (~r_iboth & ((r_irise & w_rise) | (~r_irise & w_fall)));

  assign w_wr  = r_valid && r_write;
  assign w_wd  = hwdata_s[gpio_w-1:0];
  assign w_w1c = (w_wr && (r_addr == A_ISTAT)) ? w_wd : '0;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_gpo   <= '0;
      r_gpd   <= '0;
      r_ien   <= '0;
      r_irise <= '0;
      r_iboth <= '0;
      r_istat <= '0;
    end else begin
      // Clear first, then OR in new edges so a colliding edge survives.
      r_istat <= (r_istat & ~w_w1c) | w_edge;
      if (w_wr) begin
        case (r_addr)
          A_GPO:   r_gpo   <= w_wd;
          A_GPD:   r_gpd   <= w_wd;
          A_SET:   r_gpo   <= r_gpo | w_wd;
          A_CLR:   r_gpo   <= r_gpo & ~w_wd;
          A_TGL:   r_gpo   <= r_gpo ^ w_wd;
          A_IEN:   r_ien   <= w_wd;
          A_IRISE: r_irise <= w_wd;
          A_IBOTH: r_iboth <= w_wd;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd = '0;
    if (r_valid && !r_write) begin
      case (r_addr)
        A_GPI:   w_rd = w_gpi_s;
        A_GPO:   w_rd = r_gpo;
        A_GPD:   w_rd = r_gpd;
        A_IEN:   w_rd = r_ien;
        A_IRISE: w_rd = r_irise;
        A_IBOTH: w_rd = r_iboth;
        A_ISTAT: w_rd = r_istat;
        default: w_rd = '0;
      endcase
    end
  end

  assign hrdata_s = 32'(w_rd);
  assign gpo      = r_gpo;
  assign gpd      = r_gpd;
  assign irq      = |(r_istat & r_ien);

endmodule

// File: tb/tb_nf_ahb_gpio_irq.sv
// tb/tb_nf_ahb_gpio_irq.sv - self-checking bench for nf_ahb_gpio_irq
module tb_nf_ahb_gpio_irq;

  localparam int GW = 8;
  localparam int SS = 2;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic [31:0]   haddr_s;
  logic [31:0]   hwdata_s;
  logic [31:0]   hrdata_s;
  logic          hwrite_s;
  logic [1:0]    htrans_s;
  logic [2:0]    hsize_s;
  logic [2:0]    hburst_s;
  logic [1:0]    hresp_s;
  logic          hready_s;
  logic          hsel_s;
  logic [GW-1:0] gpi;
  logic [GW-1:0] gpo;
  logic [GW-1:0] gpd;
  logic          irq;

  nf_ahb_gpio_irq #(.gpio_w(GW), .sync_stages(SS)) dut (
    .hclk(hclk), .hresetn(hresetn), .haddr_s(haddr_s), .hwdata_s(hwdata_s),
    .hrdata_s(hrdata_s), .hwrite_s(hwrite_s), .htrans_s(htrans_s),
    .hsize_s(hsize_s), .hburst_s(hburst_s), .hresp_s(hresp_s),
    .hready_s(hready_s), .hsel_s(hsel_s), .gpi(gpi), .gpo(gpo), .gpd(gpd),
    .irq(irq)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt[17];
  vec_t        xq[$];
  logic [31:0] rq[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Behavioural register file of the slave.
  logic [7:0] m_gpo, m_gpd, m_ien, m_irise, m_iboth, m_istat, m_gpi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  // Issues every transfer in xq back-to-back; read data lands in rq.
  task automatic run_b2b();
    int n = xq.size();
    rq.delete();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        hsel_s = 1'b1; htrans_s = 2'b10; haddr_s = {26'h0, xq[i].addr}; hwrite_s = xq[i].wr;
      end else begin
        hsel_s = 1'b0; htrans_s = 2'b00; haddr_s = 32'h0; hwrite_s = 1'b0;
      end
      hwdata_s = (i > 0) ? xq[i-1].data : 32'h0;
      #1;
      if (i > 0 && !xq[i-1].wr) rq.push_back(hrdata_s);
      @(posedge hclk); #1;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    xq.delete();
    xq.push_back('{1'b1, a, d, 32'h0});
    run_b2b();
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    xq.delete();
    xq.push_back('{1'b0, a, 32'h0, 32'h0});
    run_b2b();
    d = rq[0];
  endtask

  function automatic logic [31:0] m_read(input logic [5:0] a);
    logic [3:0] w = a[5:2];
    case (w)
      4'd0: return {24'h0, m_gpi};
      4'd1: return {24'h0, m_gpo};
      4'd2: return {24'h0, m_gpd};
      4'd6: return {24'h0, m_ien};
      4'd7: return {24'h0, m_irise};
      4'd8: return {24'h0, m_iboth};
      4'd9: return {24'h0, m_istat};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [5:0] a, input logic [31:0] d);
    logic [7:0] v = d[7:0];
    logic [3:0] w = a[5:2];
    case (w)
      4'd1: m_gpo = v;
      4'd2: m_gpd = v;
      4'd3: m_gpo = m_gpo | v;
      4'd4: m_gpo = m_gpo & ~v;
      4'd5: m_gpo = m_gpo ^ v;
      4'd6: m_ien = v;
      4'd7: m_irise = v;
      4'd8: m_iboth = v;
      4'd9: m_istat = m_istat & ~v;
      default: ;
    endcase
  endtask

  // New pin value: each bit's edge is judged against its configured sense.
  task automatic m_pins(input logic [7:0] nv);
    for (int b = 0; b < 8; b++) begin
      bit r = nv[b] && !m_gpi[b];
      bit f = !nv[b] && m_gpi[b];
      bit e = m_iboth[b] ? (r || f) : (m_irise[b] ? r : f);
      if (e) m_istat[b] = 1'b1;
    end
    m_gpi = nv;
  endtask

  initial begin
    logic [31:0] d;
    logic [5:0]  a;
    int          ri;

    hresetn = 1'b0; haddr_s = 0; hwdata_s = 0; hwrite_s = 0; htrans_s = 0;
    hsize_s = 3'b010; hburst_s = 0; hsel_s = 0; gpi = 0;

    // Reset state
    idle(3);
    check("rst_gpo", {24'h0, gpo}, 32'h0);
    check("rst_gpd", {24'h0, gpd}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_hready", {31'h0, hready_s}, 32'h1);
    check("rst_hresp", {30'h0, hresp_s}, 32'h0);
    check("rst_hrdata", hrdata_s, 32'h0);
    hresetn = 1'b1;
    idle(1);

    // Table: back-to-back writes/reads including atomic ops and reserved space
    vt[0]  = '{1'b1, 6'h04, 32'h0000_00A5, 32'h0};
    vt[1]  = '{1'b1, 6'h08, 32'h0000_00FF, 32'h0};
    vt[2]  = '{1'b0, 6'h04, 32'h0,         32'h0000_00A5};
    vt[3]  = '{1'b0, 6'h08, 32'h0,         32'h0000_00FF};
    vt[4]  = '{1'b0, 6'h30, 32'h0,         32'h0};
    vt[5]  = '{1'b1, 6'h04, 32'h0000_00F0, 32'h0};
    vt[6]  = '{1'b1, 6'h0C, 32'h0000_000F, 32'h0};
    vt[7]  = '{1'b1, 6'h10, 32'h0000_0030, 32'h0};
    vt[8]  = '{1'b1, 6'h14, 32'h0000_0081, 32'h0};
    vt[9]  = '{1'b0, 6'h04, 32'h0,         32'h0000_004E};
    vt[10] = '{1'b0, 6'h0C, 32'h0,         32'h0};
    vt[11] = '{1'b0, 6'h14, 32'h0,         32'h0};
    vt[12] = '{1'b1, 6'h18, 32'h1234_5601, 32'h0};
    vt[13] = '{1'b0, 6'h18, 32'h0,         32'h0000_0001};
    vt[14] = '{1'b1, 6'h30, 32'hFFFF_FFFF, 32'h0};
    vt[15] = '{1'b0, 6'h30, 32'h0,         32'h0};
    vt[16] = '{1'b1, 6'h18, 32'h0,         32'h0};
    xq.delete();
    for (int i = 0; i < 17; i++) xq.push_back(vt[i]);
    run_b2b();
    ri = 0;
    for (int i = 0; i < 17; i++) begin
      if (!vt[i].wr) begin
        check($sformatf("vec%0d_rd%02h", i, vt[i].addr), (ri < rq.size()) ? rq[ri] : 32'hDEAD_BEEF, vt[i].exp);
        ri++;
      end
    end
    check("atomic_gpo_pin", {24'h0, gpo}, 32'h4E);
    check("gpd_pin", {24'h0, gpd}, 32'hFF);

    // Synchroniser latency: GPI read follows the pin only after SS edges
    gpi = 8'h3C;
    xq.delete();
    for (int i = 0; i < 3; i++) xq.push_back('{1'b0, 6'h00, 32'h0, 32'h0});
    run_b2b();
    for (int i = 0; i < 3; i++)
      check($sformatf("sync_rd%0d", i), rq[i], (i + 1 >= SS) ? 32'h3C : 32'h0);

    // Edge interrupts: rise on pin0, fall on pin1
    gpi = 8'h00;
    idle(SS + 2);
    wr(6'h1C, 32'h01);
    wr(6'h20, 32'h00);
    wr(6'h24, 32'hFF);
    wr(6'h18, 32'h03);
    gpi = 8'h03; idle(SS + 2);
    gpi = 8'h00; idle(SS + 2);
    rd(6'h24, d);
    check("istat_both", d, 32'h03);
    check("irq_set", {31'h0, irq}, 32'h1);
    wr(6'h24, 32'h01);
    rd(6'h24, d);
    check("istat_w1c0", d, 32'h02);
    check("irq_still", {31'h0, irq}, 32'h1);
    wr(6'h24, 32'h02);
    check("irq_clr", {31'h0, irq}, 32'h0);

    // Collision: W1C of bit2 on the same edge that latches a new pin2 edge
    wr(6'h20, 32'h04);
    gpi = 8'h04; idle(SS + 2);
    rd(6'h24, d);
    check("istat_pre_coll", d, 32'h04);
    gpi = 8'h00;
    if (SS > 1) idle(SS - 1);
    wr(6'h24, 32'h04);
    rd(6'h24, d);
    check("istat_collision", d, 32'h04);
    idle(SS + 2);

    // Reset during the data phase of a GPO write
    hsel_s = 1'b1; htrans_s = 2'b10; haddr_s = 32'h04; hwrite_s = 1'b1;
    @(posedge hclk); #1;
    hsel_s = 1'b0; htrans_s = 2'b00; haddr_s = 32'h0; hwrite_s = 1'b0;
    hwdata_s = 32'hFF;
    #2 hresetn = 1'b0;
    #1 check("rst_async_gpo", {24'h0, gpo}, 32'h0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    idle(1);
    check("rst_mid_gpo", {24'h0, gpo}, 32'h0);
    rd(6'h24, d);
    check("rst_mid_istat", d, 32'h0);
    check("rst_mid_irq", {31'h0, irq}, 32'h0);

    // Randomised traffic against the register-level model
    m_gpo = 0; m_gpd = 0; m_ien = 0; m_irise = 0; m_iboth = 0; m_istat = 0; m_gpi = 0;
    for (int r = 0; r < 150; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        logic [7:0] nv = 8'($urandom);
        m_pins(nv);
        gpi = nv;
        idle(SS + 2);
      end
      a = 6'($urandom_range(0, 15) << 2);
      d = $urandom;
      wr(a, d);
      m_write(a, d);
      a = 6'($urandom_range(0, 15) << 2);
      rd(a, d);
      check($sformatf("rnd%0d_rd%02h", r, a), d, m_read(a));
      check($sformatf("rnd%0d_pins", r), {15'h0, irq, gpd, gpo}, {15'h0, |(m_istat & m_ien), m_gpd, m_gpo});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nf_ahb_gpio_irq.md
# nf_ahb_gpio_irq

Parametrised AHB-Lite GPIO slave for the nanoFOX peripheral bus. It extends the basic GPIO slave in four ways: atomic set/clear/toggle of outputs, a configurable input synchroniser, per-pin edge-detect interrupts with write-1-to-clear status, and a combined interrupt line to the core. It connects to one slave port of the AHB interconnect, and its pins go to the board I/O.

## Interface
Parameters:
- gpio_w, 8, number of GPIO pins (1..32)
- sync_stages, 2, flip-flop stages on gpi before any use (≥2)

Ports:
- hclk  input  1  AHB clock; single clock domain
- hresetn  input  1  asynchronous, active-low reset
- haddr_s  input  32  AHB address; only haddr_s[5:2] decoded
- hwdata_s  input  32  write data (data phase)
- hrdata_s  output  32  read data (data phase)
- hwrite_s  input  1  1 = write
- htrans_s  input  2  IDLE/BUSY/NONSEQ/SEQ
- hsize_s  input  3  ignored; every access is a 32-bit word
- hburst_s  input  3  ignored
- hresp_s  output  2  constant OKAY
- hready_s  output  1  HREADYOUT, constant 1 (zero wait states)
- hsel_s  input  1  slave select
- gpi  input  gpio_w  asynchronous pin inputs
- gpo  output  gpio_w  output values
- gpd  output  gpio_w  direction, 1 = output
- irq  output  1  level interrupt to core

## Operation
- Request = hsel_s && htrans_s != IDLE. On a request, the address, hwrite_s and a valid flag are registered (address phase). The following cycle is the data phase.
- Register map (word offset, access, reset value):
  - 0x00 GPI: RO, synchronised input.
  - 0x04 GPO: RW, reset 0.
  - 0x08 GPD: RW, reset 0.
  - 0x0C SET: WO, gpo |= wd.
  - 0x10 CLR: WO, gpo &= ~wd.
  - 0x14 TGL: WO, gpo ^= wd.
  - 0x18 IEN: RW, reset 0.
  - 0x1C IRISE: RW, 1 = rising, 0 = falling, reset 0.
  - 0x20 IBOTH: RW, 1 = both edges (overrides IRISE), reset 0.
  - 0x24 ISTAT: read returns status; write 1 clears that bit, write 0 leaves it unchanged.
  - 0x28–0x3C: reserved; reads return 0, writes are ignored.
- The write-only registers (SET/CLR/TGL) read as 0.
- Only bits [gpio_w-1:0] are stored. Upper read bits return 0 and upper write bits are ignored.
- Synchroniser and edge detection:
  - gpi_s = gpi after sync_stages flops.
  - gpi_p = gpi_s delayed by one cycle.
  - rise = gpi_s & ~gpi_p; fall = ~gpi_s & gpi_p.
  - edge[i] = IBOTH[i] ? (rise|fall) : (IRISE[i] ? rise : fall).
- ISTAT[i] sets on edge[i] regardless of IEN[i]. Only IEN gates the interrupt.
- irq = |(ISTAT & IEN), combinational from registers.
- Simultaneous events:
  - A W1C write to ISTAT and a new edge on the same bit in the same cycle: the set wins.
  - Pins in input direction (gpd = 0) still drive gpo with the register value; external tri-state logic uses gpd.
- hrdata_s = selected register during a data-phase read, otherwise 0.
- Back-to-back transfers are supported. A new address phase may overlap the current data phase.

## Timing
- Reset values: gpo, gpd, IEN, IRISE, IBOTH, ISTAT, synchroniser flops, gpi_p and the address registers are all 0. irq is 0 and hrdata_s is 0. hready_s is 1 and hresp_s is OKAY at all times, including during reset.
- A write takes effect at the rising edge that ends its data phase. gpo/gpd change one cycle after the address phase. A read of the same register in the next transfer returns the new value.
- Read data is valid during the data phase, one cycle after the address phase.
- gpi change to GPI readback: sync_stages cycles.
- gpi change to ISTAT set and irq high: sync_stages+1 edges.
- irq deasserts in the cycle after the W1C data-phase edge (or the IEN clear).
- hresetn assertion mid-transfer clears all state asynchronously. A pending data-phase write is lost.

## Test plan
- Reset/readback:
  - Stimulus: hold hresetn low.
  - Required: gpo=0, gpd=0, irq=0, hready_s=1.
  - Stimulus: write GPO=0xA5 then GPD=0xFF, back-to-back.
  - Required: read GPO=0x000000A5, GPD=0x000000FF; reserved 0x30 reads 0.
- Atomic ops:
  - Stimulus: GPO=0xF0, then SET 0x0F, CLR 0x30, TGL 0x81.
  - Required: gpo=0x4E; SET reads 0.
- Sync latency:
  - Stimulus: gpi 0x00→0x3C.
  - Required: GPI read reflects 0x3C no earlier than sync_stages cycles later.
- Edge interrupts:
  - Stimulus: IEN=0x03, IRISE=0x01, IBOTH=0x00, then pulse gpi[0] 0→1→0 and gpi[1] 0→1→0.
  - Required: ISTAT=0x03 (bit0 from the rise, bit1 from the fall); irq=1.
  - Stimulus: write ISTAT=0x01.
  - Required: ISTAT=0x02, irq stays 1.
  - Stimulus: write ISTAT=0x02.
  - Required: irq=0.
- Collision: a W1C of ISTAT bit2 in the same cycle as a new edge on pin2 leaves ISTAT[2]=1.
- Reset mid-operation: assert hresetn during the data phase of a GPO write of 0xFF → gpo=0 after reset, and ISTAT=0.
